// File: rtl/bru_bco_pht_updater_if.sv
`default_nettype none
// ============================================================================
// Module      : bru_bco_pht_updater_if
// Description : BCO record channel, fetch lookup port and status outputs of
//               the PHT updater, grouped for connection as a single port.
// Revision    : 1.0 - initial release
// ============================================================================
interface bru_bco_pht_updater_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          i_bco_valid;
    logic [31:0]   i_bco_pc;
    logic [1:0]    i_bco_oldpattern;
    logic          i_bco_taken;
    logic [31:0]   i_bco_target;
    logic          i_lk_valid;
    logic [31:0]   i_lk_pc;
    logic          o_lk_valid;
    logic [1:0]    o_lk_pattern;
    logic [31:0]   o_lk_target;
    logic          o_init_done;
    logic [CW-1:0] o_fifo_count;
    logic          o_overflow;

    // Producer / fetch side
    modport master (
        output i_bco_valid, i_bco_pc, i_bco_oldpattern, i_bco_taken, i_bco_target,
        output i_lk_valid, i_lk_pc,
        input  o_lk_valid, o_lk_pattern, o_lk_target, o_init_done, o_fifo_count, o_overflow
    );

    // Updater side
    modport slave (
        input  i_bco_valid, i_bco_pc, i_bco_oldpattern, i_bco_taken, i_bco_target,
        input  i_lk_valid, i_lk_pc,
        output o_lk_valid, o_lk_pattern, o_lk_target, o_init_done, o_fifo_count, o_overflow
    );
endinterface
`default_nettype wire

// File: rtl/bru_bco_pht_updater.sv
`default_nettype none
// ============================================================================
// Module      : bru_bco_pht_updater
// Description : Buffers BRU branch-commit-override records in a small FIFO and
//               drains them into a single-ported 2-bit PHT plus target table.
//               Fetch lookups share the table port and win over updates.
// Revision    : 1.0 - initial release
// ============================================================================
module bru_bco_pht_updater #(
    parameter int PHT_AW     = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    bru_bco_pht_updater_if.slave  bco
);
    localparam int ENTRIES = 1 << PHT_AW;
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CW      = PW + 1;
    localparam logic [CW-1:0]     FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [PHT_AW-1:0] LAST_IDX   = PHT_AW'(ENTRIES - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PHT_AW-1:0] init_idx;

    // Table storage (no reset: the INIT sweep establishes contents)
    logic [1:0]        pht [ENTRIES];
    logic [31:0]       btt [ENTRIES];

    // FIFO storage keeps only the index bits of the PC
    logic [PHT_AW-1:0] fifo_idx    [FIFO_DEPTH];
    logic [1:0]        fifo_old    [FIFO_DEPTH];
    logic              fifo_taken  [FIFO_DEPTH];
    logic [31:0]       fifo_target [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              overflow;

    logic              running;
    logic              fifo_full;
    logic              pop;
    logic              push;
    logic [1:0]        new_pattern;
    logic [PHT_AW-1:0] lk_idx;

    logic              lk_valid;
    logic [1:0]        lk_pattern;
    logic [31:0]       lk_target;

    // PC bits outside the table index are intentionally ignored
    logic              unused_pc_bits;
    assign unused_pc_bits = ^{bco.i_bco_pc[31:PHT_AW+2], bco.i_bco_pc[1:0],
                              bco.i_lk_pc[31:PHT_AW+2],  bco.i_lk_pc[1:0]};

    assign running   = (state == ST_RUN);
    assign fifo_full = (count == FULL_COUNT);
    // Lookups own the table port; updates only happen in idle lookup cycles
    assign pop       = running && (count != '0) && !bco.i_lk_valid;
    // A full FIFO still accepts a record when the head leaves in the same cycle
    assign push      = bco.i_bco_valid && (!fifo_full || pop);
    assign lk_idx    = bco.i_lk_pc[PHT_AW+1:2];

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_INIT;
        else         state <= state_next;
    end

    // FSM next state: leave INIT after the last entry has been written
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (init_idx == LAST_IDX) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    // Initialisation sweep index
    always_ff @(posedge clk) begin
        if (!resetn)               init_idx <= '0;
        else if (state == ST_INIT) init_idx <= init_idx + 1'b1;
    end

    // Saturating 2-bit counter update for the FIFO head record
    always_comb begin
        new_pattern = fifo_old[rd_ptr];
        if (fifo_taken[rd_ptr]) begin
            if (fifo_old[rd_ptr] != 2'b11) new_pattern = fifo_old[rd_ptr] + 2'd1;
        end else begin
            if (fifo_old[rd_ptr] != 2'b00) new_pattern = fifo_old[rd_ptr] - 2'd1;
        end
    end

    // Table write port: sweep during INIT, head-record update during RUN
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            pht[init_idx] <= 2'b01;
            btt[init_idx] <= '0;
        end else if (pop) begin
            pht[fifo_idx[rd_ptr]] <= new_pattern;
            if (fifo_taken[rd_ptr]) btt[fifo_idx[rd_ptr]] <= fifo_target[rd_ptr];
        end
    end

    // Registered lookup response; data holds when no RUN lookup occurs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lk_valid   <= 1'b0;
            lk_pattern <= '0;
            lk_target  <= '0;
        end else begin
            lk_valid <= running && bco.i_lk_valid;
            if (running && bco.i_lk_valid) begin
                lk_pattern <= pht[lk_idx];
                lk_target  <= btt[lk_idx];
            end
        end
    end

    // FIFO record storage
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[wr_ptr]    <= bco.i_bco_pc[PHT_AW+1:2];
            fifo_old[wr_ptr]    <= bco.i_bco_oldpattern;
            fifo_taken[wr_ptr]  <= bco.i_bco_taken;
            fifo_target[wr_ptr] <= bco.i_bco_target;
        end
    end

    // FIFO pointers, occupancy and sticky drop flag
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            if (bco.i_bco_valid && !push) overflow <= 1'b1;
        end
    end

    assign bco.o_lk_valid   = lk_valid;
    assign bco.o_lk_pattern = lk_pattern;
    assign bco.o_lk_target  = lk_target;
    assign bco.o_init_done  = running;
    assign bco.o_fifo_count = count;
    assign bco.o_overflow   = overflow;
endmodule
`default_nettype wire

// File: tb/tb_bru_bco_pht_updater.sv
`default_nettype none
// ============================================================================
// Module      : tb_bru_bco_pht_updater
// Description : Self-checking bench for bru_bco_pht_updater; directed plan
//               followed by randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bru_bco_pht_updater;
    localparam int PHT_AW     = 6;
    localparam int FIFO_DEPTH = 4;
    localparam int N          = 1 << PHT_AW;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bru_bco_pht_updater_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    bru_bco_pht_updater #(.PHT_AW(PHT_AW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bco    (bus)
    );

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [31:0] pc;
        int          old;
        bit          taken;
        logic [31:0] target;
    } rec_t;

    int          m_pht [N];
    logic [31:0] m_tgt [N];
    rec_t        m_q [$];
    bit          m_run;
    int          m_init_cnt;
    bit          m_ovf;
    bit          e_lkv;
    int          e_pat;
    logic [31:0] e_tgt;

    function automatic int tidx(logic [31:0] pc);
        return int'(pc >> 2) % N;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_step();
        bit   do_pop;
        rec_t r;
        int   v;
        if (!resetn) begin
            m_q.delete();
            m_run = 0; m_init_cnt = 0; m_ovf = 0;
            e_lkv = 0; e_pat = 0; e_tgt = 0;
            for (int i = 0; i < N; i++) begin m_pht[i] = 1; m_tgt[i] = 0; end
            return;
        end
        e_lkv = m_run && bus.i_lk_valid;
        if (e_lkv) begin
            e_pat = m_pht[tidx(bus.i_lk_pc)];
            e_tgt = m_tgt[tidx(bus.i_lk_pc)];
        end
        do_pop = m_run && (m_q.size() != 0) && !bus.i_lk_valid;
        if (do_pop) begin
            r = m_q.pop_front();
            v = r.taken ? r.old + 1 : r.old - 1;
            if (v > 3) v = 3;
            if (v < 0) v = 0;
            m_pht[tidx(r.pc)] = v;
            if (r.taken) m_tgt[tidx(r.pc)] = r.target;
        end
        if (bus.i_bco_valid) begin
            if (m_q.size() < FIFO_DEPTH)
                m_q.push_back('{bus.i_bco_pc, int'(bus.i_bco_oldpattern), bus.i_bco_taken, bus.i_bco_target});
            else
                m_ovf = 1;
        end
        if (!m_run) begin
            m_init_cnt++;
            if (m_init_cnt == N) m_run = 1;
        end
    endtask

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("lk_valid",   32'(bus.o_lk_valid),   32'(e_lkv));
        check("lk_pattern", 32'(bus.o_lk_pattern), 32'(e_pat));
        check("lk_target",  bus.o_lk_target,       e_tgt);
        check("init_done",  32'(bus.o_init_done),  32'(m_run));
        check("fifo_count", 32'(bus.o_fifo_count), 32'(m_q.size()));
        check("overflow",   32'(bus.o_overflow),   32'(m_ovf));
    endtask

    // One clock: model sees pre-edge inputs, outputs compared 1 time unit later
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(bit bv, logic [31:0] pc, logic [1:0] op, bit tk,
                         logic [31:0] tg, bit lv, logic [31:0] lpc);
        bus.i_bco_valid      = bv;
        bus.i_bco_pc         = pc;
        bus.i_bco_oldpattern = op;
        bus.i_bco_taken      = tk;
        bus.i_bco_target     = tg;
        bus.i_lk_valid       = lv;
        bus.i_lk_pc          = lpc;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle();
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        idle();
        // 1: reset values and exact sweep length
        do_reset();
        check("rst_count", 32'(bus.o_fifo_count), 0);
        check("rst_pattern", 32'(bus.o_lk_pattern), 0);
        repeat (N - 1) tick();
        check("init_before_64", 32'(bus.o_init_done), 0);
        tick();
        check("init_at_64", 32'(bus.o_init_done), 1);
        drive(0, 0, 0, 0, 0, 1, 32'h100);
        tick();
        check("t1_valid", 32'(bus.o_lk_valid), 1);
        check("t1_pattern", 32'(bus.o_lk_pattern), 1);
        check("t1_target", bus.o_lk_target, 0);

        // 2: taken update increments and writes target
        drive(1, 32'h40, 2'b01, 1, 32'h2000, 0, 0);
        tick();
        idle();
        tick();
        drive(0, 0, 0, 0, 0, 1, 32'h40);
        tick();
        check("t2_pattern", 32'(bus.o_lk_pattern), 2);
        check("t2_target", bus.o_lk_target, 32'h2000);

        // 3: saturation both ways, not-taken keeps target
        drive(1, 32'h44, 2'b11, 1, 32'h3000, 0, 0);
        tick();
        idle();
        tick();
        drive(0, 0, 0, 0, 0, 1, 32'h44);
        tick();
        check("t3_sat_hi", 32'(bus.o_lk_pattern), 3);
        drive(1, 32'h40, 2'b00, 0, 32'h5555, 0, 0);
        tick();
        idle();
        tick();
        drive(0, 0, 0, 0, 0, 1, 32'h40);
        tick();
        check("t3_sat_lo", 32'(bus.o_lk_pattern), 0);
        check("t3_keep_tgt", bus.o_lk_target, 32'h2000);

        // 5: full FIFO with simultaneous pop and push
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h80 + 32'(4 * i), 2'(i), 1, 32'hA000 + 32'(i), 1, 32'h80);
            tick();
        end
        check("t5_full", 32'(bus.o_fifo_count), 4);
        drive(1, 32'h90, 2'b10, 0, 32'hB000, 0, 0);
        tick();
        check("t5_count", 32'(bus.o_fifo_count), 4);
        check("t5_no_ovf", 32'(bus.o_overflow), 0);
        idle();
        repeat (5) tick();

        // 4: lookups block updates, fifth record dropped, then ordered drain
        for (int i = 0; i < 10; i++) begin
            if (i < 5) drive(1, 32'hC0 + 32'(4 * (i % 3)), 2'(i), i[0], 32'hC000 + 32'(i), 1, 32'hC0);
            else       drive(0, 0, 0, 0, 0, 1, 32'hC0 + 32'(4 * (i % 3)));
            tick();
        end
        check("t4_count", 32'(bus.o_fifo_count), 4);
        check("t4_ovf", 32'(bus.o_overflow), 1);
        idle();
        for (int k = 3; k >= 0; k--) begin
            tick();
            check("t4_drain", 32'(bus.o_fifo_count), 32'(k));
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 1, 32'hC0 + 32'(4 * i));
            tick();
        end

        // 6: reset with records pending, records accepted during INIT
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h20 + 32'(4 * i), 2'b10, 1, 32'hD000, 1, 32'h20);
            tick();
        end
        check("t6_pending", 32'(bus.o_fifo_count), 3);
        do_reset();
        check("t6_rst_count", 32'(bus.o_fifo_count), 0);
        check("t6_rst_init", 32'(bus.o_init_done), 0);
        for (int i = 0; i < N; i++) begin
            if (i < 3) drive(1, 32'h60 + 32'(4 * i), 2'b01, 1, 32'hE000 + 32'(i), 0, 0);
            else       idle();
            tick();
        end
        check("t6_done", 32'(bus.o_init_done), 1);
        idle();
        repeat (4) tick();
        drive(0, 0, 0, 0, 0, 1, 32'h64);
        tick();
        check("t6_applied_pat", 32'(bus.o_lk_pattern), 2);
        check("t6_applied_tgt", bus.o_lk_target, 32'hE001);

        // Randomized traffic on a small index set to force collisions
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] pc;
            logic [31:0] lpc;
            pc  = ($urandom() & ~32'hFC) | (32'($urandom_range(0, 7)) << 2);
            lpc = ($urandom() & ~32'hFC) | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 99) < 45, pc, 2'($urandom()), 1'($urandom()),
                      $urandom(), $urandom_range(0, 99) < 40, lpc);
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
